// File: rtl/riscv_pkg.sv
// Shared integer-pipeline constants and types for the register file writer side.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  // Origin of the value currently presented on the register file write port.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LOAD = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_load_queue.sv
// In-order load queue: allocated at issue, filled by returning data, drained at the head.
module wb_load_queue #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int LQ_DEPTH = 4,
  parameter int LQ_CW    = $clog2(LQ_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            alloc_i,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] alloc_rd_i,
  input  logic                            fill_i,
  input  logic [XLEN-1:0]                 fill_data_i,
  input  logic                            drain_i,
  output logic [LQ_CW-1:0]                count_o,
  output logic                            head_filled_o,
  output logic [riscv_pkg::REG_ADDR_W-1:0] head_rd_o,
  output logic [XLEN-1:0]                 head_data_o,
  output logic                            fill_err_o
);
  import riscv_pkg::*;

  localparam int PW = $clog2(LQ_DEPTH);

  logic [PW-1:0]         alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]         fill_ptr_q,  fill_ptr_d;
  logic [PW-1:0]         drain_ptr_q, drain_ptr_d;
  logic [LQ_CW-1:0]      count_q,     count_d;
  logic [LQ_CW-1:0]      pend_q,      pend_d;
  logic [REG_ADDR_W-1:0] ent_rd_q     [LQ_DEPTH];
  logic [REG_ADDR_W-1:0] ent_rd_d     [LQ_DEPTH];
  logic [XLEN-1:0]       ent_data_q   [LQ_DEPTH];
  logic [XLEN-1:0]       ent_data_d   [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]   ent_filled_q, ent_filled_d;
  logic [LQ_DEPTH-1:0]   ent_valid_q,  ent_valid_d;
  logic                  fill_ok;

  // pend_q counts allocated-but-unfilled entries, so a full queue of
  // unfilled loads (fill_ptr == alloc_ptr) is still distinguishable from none.
  assign fill_ok       = fill_i && (pend_q != '0);
  assign fill_err_o    = fill_i && (pend_q == '0);
  assign count_o       = count_q;
  assign head_filled_o = ent_valid_q[drain_ptr_q] && ent_filled_q[drain_ptr_q];
  assign head_rd_o     = ent_rd_q[drain_ptr_q];
  assign head_data_o   = ent_data_q[drain_ptr_q];

  // Next-state for entries, pointers and counters; the three ports never hit the same slot.
  always_comb begin
    alloc_ptr_d  = alloc_ptr_q;
    fill_ptr_d   = fill_ptr_q;
    drain_ptr_d  = drain_ptr_q;
    ent_rd_d     = ent_rd_q;
    ent_data_d   = ent_data_q;
    ent_filled_d = ent_filled_q;
    ent_valid_d  = ent_valid_q;
    count_d      = count_q;
    pend_d       = pend_q;

    if (alloc_i) begin
      ent_rd_d[alloc_ptr_q]     = alloc_rd_i;
      ent_filled_d[alloc_ptr_q] = 1'b0;
      ent_valid_d[alloc_ptr_q]  = 1'b1;
      alloc_ptr_d               = alloc_ptr_q + PW'(1);
    end
    if (fill_ok) begin
      ent_data_d[fill_ptr_q]   = fill_data_i;
      ent_filled_d[fill_ptr_q] = 1'b1;
      fill_ptr_d               = fill_ptr_q + PW'(1);
    end
    if (drain_i) begin
      ent_filled_d[drain_ptr_q] = 1'b0;
      ent_valid_d[drain_ptr_q]  = 1'b0;
      drain_ptr_d               = drain_ptr_q + PW'(1);
    end

    case ({alloc_i, drain_i})
      2'b10:   count_d = count_q + LQ_CW'(1);
      2'b01:   count_d = count_q - LQ_CW'(1);
      default: count_d = count_q;
    endcase
    case ({alloc_i, fill_ok})
      2'b10:   pend_d = pend_q + LQ_CW'(1);
      2'b01:   pend_d = pend_q - LQ_CW'(1);
      default: pend_d = pend_q;
    endcase
  end

  // Queue state registers; reset discards any loads still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_ptr_q  <= '0;
      fill_ptr_q   <= '0;
      drain_ptr_q  <= '0;
      count_q      <= '0;
      pend_q       <= '0;
      ent_filled_q <= '0;
      ent_valid_q  <= '0;
      for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      alloc_ptr_q  <= alloc_ptr_d;
      fill_ptr_q   <= fill_ptr_d;
      drain_ptr_q  <= drain_ptr_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      ent_filled_q <= ent_filled_d;
      ent_valid_q  <= ent_valid_d;
      ent_rd_q     <= ent_rd_d;
      ent_data_q   <= ent_data_d;
    end
  end

endmodule

// File: rtl/regfile_writeback_unit.sv
// Register file writer: ALU-priority arbitration against in-order load returns,
// registered write port, and per-register pending-load scoreboard.
module regfile_writeback_unit #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int LQ_DEPTH = 4,
  parameter int LQ_CW    = $clog2(LQ_DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             alu_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]                  alu_data,
  input  logic                             ld_issue_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] ld_issue_rd,
  output logic                             ld_issue_ready,
  input  logic                             ld_rsp_valid,
  input  logic [XLEN-1:0]                  ld_rsp_data,
  output logic                             wr_en,
  output logic [riscv_pkg::REG_ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]                  wr_data,
  output logic [riscv_pkg::NUM_REGS-1:0]   sb_busy,
  output logic [LQ_CW-1:0]                 lq_count,
  output logic                             protocol_err
);
  import riscv_pkg::*;

  logic                  wr_en_q,   wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  wb_src_e               wr_src_q,  wr_src_d;
  logic [NUM_REGS-1:0]   sb_busy_q, sb_busy_d;
  logic                  err_q,     err_d;

  logic                  issue_acc;
  logic                  drain;
  logic                  head_filled;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  fill_err;

  // x0 is never marked busy, so it never blocks an issue.
  assign ld_issue_ready = (lq_count < LQ_CW'(LQ_DEPTH)) && !sb_busy_q[ld_issue_rd];
  assign issue_acc      = ld_issue_valid && ld_issue_ready;
  assign drain          = !alu_valid && head_filled;

  wb_load_queue #(
    .XLEN     (XLEN),
    .LQ_DEPTH (LQ_DEPTH),
    .LQ_CW    (LQ_CW)
  ) u_lq (
    .clk           (clk),
    .reset         (reset),
    .alloc_i       (issue_acc),
    .alloc_rd_i    (ld_issue_rd),
    .fill_i        (ld_rsp_valid),
    .fill_data_i   (ld_rsp_data),
    .drain_i       (drain),
    .count_o       (lq_count),
    .head_filled_o (head_filled),
    .head_rd_o     (head_rd),
    .head_data_o   (head_data),
    .fill_err_o    (fill_err)
  );

  // Write-port arbitration, scoreboard update and sticky error accumulation.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = WB_NONE;
    sb_busy_d = sb_busy_q;
    err_d     = err_q || fill_err || (alu_valid && sb_busy_q[alu_rd]);

    // The load written last cycle is now in the register file.
    if (wr_en_q && (wr_src_q == WB_LOAD)) begin
      sb_busy_d[wr_addr_q] = 1'b0;
    end

    if (alu_valid) begin
      wr_en_d   = (alu_rd != REG_X0);
      wr_addr_d = alu_rd;
      wr_data_d = alu_data;
      wr_src_d  = WB_ALU;
    end else if (drain) begin
      wr_en_d   = (head_rd != REG_X0);
      wr_addr_d = head_rd;
      wr_data_d = head_data;
      wr_src_d  = WB_LOAD;
    end

    if (issue_acc && (ld_issue_rd != REG_X0)) begin
      sb_busy_d[ld_issue_rd] = 1'b1;
    end
  end

  // Registered write port and scoreboard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= WB_NONE;
      sb_busy_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
      sb_busy_q <= sb_busy_d;
      err_q     <= err_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign sb_busy      = sb_busy_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Self-checking bench for regfile_writeback_unit: directed vector table,
// hand-written corner sequences, and randomized traffic against a queue model.
module tb_regfile_writeback_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_issue_valid = 1'b0;
  logic [4:0]  ld_issue_rd = '0;
  logic        ld_issue_ready;
  logic        ld_rsp_valid = 1'b0;
  logic [31:0] ld_rsp_data = '0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] sb_busy;
  logic [2:0]  lq_count;
  logic        protocol_err;

  int checks = 0;
  int failures = 0;

  regfile_writeback_unit #(.XLEN(32), .LQ_DEPTH(DEPTH), .LQ_CW(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_rd    (ld_issue_rd),
    .ld_issue_ready (ld_issue_ready),
    .ld_rsp_valid   (ld_rsp_valid),
    .ld_rsp_data    (ld_rsp_data),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .sb_busy        (sb_busy),
    .lq_count       (lq_count),
    .protocol_err   (protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          filled;
  } ent_t;

  ent_t        mq[$];
  bit [31:0]   m_sb;
  bit          m_err;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_last_load;

  function automatic bit model_ready(input logic [4:0] rd);
    return (mq.size() < DEPTH) && !m_sb[rd];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_sb = '0; m_err = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_last_load = 0;
  endtask

  // One clock edge of the unit, evaluated from the inputs held across it.
  task automatic model_step();
    bit        acc;
    bit        drn;
    int        k;
    bit [31:0] nsb;
    ent_t      e;
    acc = ld_issue_valid && model_ready(ld_issue_rd);
    drn = !alu_valid && (mq.size() > 0) && mq[0].filled;
    k = -1;
    foreach (mq[i]) if (k < 0 && !mq[i].filled) k = i;
    nsb = m_sb;
    if (m_last_load) nsb[m_waddr] = 1'b0;
    if (alu_valid && m_sb[alu_rd]) m_err = 1;
    if (ld_rsp_valid) begin
      if (k < 0) m_err = 1;
      else begin
        e = mq[k]; e.data = ld_rsp_data; e.filled = 1; mq[k] = e;
      end
    end
    if (alu_valid) begin
      m_wen = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data; m_last_load = 0;
    end else if (drn) begin
      e = mq.pop_front();
      m_wen = (e.rd != 0); m_waddr = e.rd; m_wdata = e.data; m_last_load = m_wen;
    end else begin
      m_wen = 0; m_last_load = 0;
    end
    if (acc) begin
      e.rd = ld_issue_rd; e.data = '0; e.filled = 0;
      mq.push_back(e);
      if (ld_issue_rd != 0) nsb[ld_issue_rd] = 1'b1;
    end
    m_sb = nsb;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("wr_en",        32'(wr_en),        32'(m_wen));
    chk("wr_addr",      32'(wr_addr),      32'(m_waddr));
    chk("wr_data",      wr_data,           m_wdata);
    chk("sb_busy",      sb_busy,           m_sb);
    chk("lq_count",     32'(lq_count),     32'(mq.size()));
    chk("protocol_err", 32'(protocol_err), 32'(m_err));
  endtask

  task automatic cyc(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                     input bit iv, input logic [4:0] ir, input bit rv, input logic [31:0] rdat);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_issue_valid = iv; ld_issue_rd = ir;
    ld_rsp_valid = rv; ld_rsp_data = rdat;
    #1;
    chk("ld_issue_ready", 32'(ld_issue_ready), 32'(model_ready(ir)));
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_issue_valid = 0; ld_issue_rd = '0;
    ld_rsp_valid = 0; ld_rsp_data = '0;
  endtask

  // Asserts reset away from any clock edge and checks the outputs clear at once.
  task automatic do_reset();
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_wr_en",    32'(wr_en),        32'h0);
    chk("rst_wr_addr",  32'(wr_addr),      32'h0);
    chk("rst_wr_data",  wr_data,           32'h0);
    chk("rst_sb_busy",  sb_busy,           32'h0);
    chk("rst_lq_count", 32'(lq_count),     32'h0);
    chk("rst_err",      32'(protocol_err), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          av; logic [4:0] ar; logic [31:0] ad;
    bit          iv; logic [4:0] ir;
    bit          rv; logic [31:0] rdat;
    bit          e_wen; logic [4:0] e_addr; logic [31:0] e_data;
    int          e_cnt; logic [31:0] e_sb; bit e_err;
  } vec_t;

  function automatic vec_t mk(bit av, logic [4:0] ar, logic [31:0] ad, bit iv, logic [4:0] ir,
                              bit rv, logic [31:0] rdat, bit ew, logic [4:0] ea,
                              logic [31:0] ed, int ec, logic [31:0] es, bit ee);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.iv = iv; v.ir = ir; v.rv = rv; v.rdat = rdat;
    v.e_wen = ew; v.e_addr = ea; v.e_data = ed; v.e_cnt = ec; v.e_sb = es; v.e_err = ee;
    return v;
  endfunction

  vec_t tbl[22];

  initial begin
    logic [4:0] r;
    bit         av, iv, rv;
    int         unfilled;

    //           av ar  ad            iv ir  rv rdat          wen addr data         cnt sb          err
    tbl[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0, 0,            1,  5,   32'hDEADBEEF, 0, 32'h0,      0);
    tbl[1]  = mk(0, 0,  0,            1, 7,  0, 0,            0,  5,   32'hDEADBEEF, 1, 32'h80,     0);
    tbl[2]  = mk(0, 0,  0,            0, 0,  0, 0,            0,  5,   32'hDEADBEEF, 1, 32'h80,     0);
    tbl[3]  = mk(0, 0,  0,            0, 0,  0, 0,            0,  5,   32'hDEADBEEF, 1, 32'h80,     0);
    tbl[4]  = mk(0, 0,  0,            0, 0,  0, 0,            0,  5,   32'hDEADBEEF, 1, 32'h80,     0);
    tbl[5]  = mk(0, 0,  0,            0, 0,  1, 32'h12345678, 0,  5,   32'hDEADBEEF, 1, 32'h80,     0);
    tbl[6]  = mk(0, 0,  0,            0, 0,  0, 0,            1,  7,   32'h12345678, 0, 32'h80,     0);
    tbl[7]  = mk(0, 0,  0,            0, 0,  0, 0,            0,  7,   32'h12345678, 0, 32'h0,      0);
    tbl[8]  = mk(0, 0,  0,            1, 3,  0, 0,            0,  7,   32'h12345678, 1, 32'h8,      0);
    tbl[9]  = mk(0, 0,  0,            0, 0,  1, 32'hAAAA0003, 0,  7,   32'h12345678, 1, 32'h8,      0);
    tbl[10] = mk(1, 4,  32'h44,       0, 0,  0, 0,            1,  4,   32'h44,       1, 32'h8,      0);
    tbl[11] = mk(1, 4,  32'h45,       0, 0,  0, 0,            1,  4,   32'h45,       1, 32'h8,      0);
    tbl[12] = mk(0, 0,  0,            0, 0,  0, 0,            1,  3,   32'hAAAA0003, 0, 32'h8,      0);
    tbl[13] = mk(0, 0,  0,            0, 0,  0, 0,            0,  3,   32'hAAAA0003, 0, 32'h0,      0);
    tbl[14] = mk(0, 0,  0,            1, 0,  0, 0,            0,  3,   32'hAAAA0003, 1, 32'h0,      0);
    tbl[15] = mk(0, 0,  0,            0, 0,  1, 32'h5555,     0,  3,   32'hAAAA0003, 1, 32'h0,      0);
    tbl[16] = mk(0, 0,  0,            0, 0,  0, 0,            0,  0,   32'h5555,     0, 32'h0,      0);
    tbl[17] = mk(0, 0,  0,            1, 2,  0, 0,            0,  0,   32'h5555,     1, 32'h4,      0);
    tbl[18] = mk(1, 2,  32'h77,       0, 0,  0, 0,            1,  2,   32'h77,       1, 32'h4,      1);
    tbl[19] = mk(0, 0,  0,            0, 0,  1, 32'h88,       0,  2,   32'h77,       1, 32'h4,      1);
    tbl[20] = mk(0, 0,  0,            0, 0,  0, 0,            1,  2,   32'h88,       0, 32'h4,      1);
    tbl[21] = mk(0, 0,  0,            0, 0,  0, 0,            0,  2,   32'h88,       0, 32'h0,      1);

    model_reset();
    #12;
    do_reset();

    foreach (tbl[i]) begin
      cyc(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].iv, tbl[i].ir, tbl[i].rv, tbl[i].rdat);
      chk($sformatf("tbl%0d_wr_en", i),   32'(wr_en),        32'(tbl[i].e_wen));
      chk($sformatf("tbl%0d_wr_addr", i), 32'(wr_addr),      32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_wr_data", i), wr_data,           tbl[i].e_data);
      chk($sformatf("tbl%0d_lq_count", i),32'(lq_count),     32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_sb_busy", i), sb_busy,           tbl[i].e_sb);
      chk($sformatf("tbl%0d_err", i),     32'(protocol_err), 32'(tbl[i].e_err));
    end

    // Full queue: ready drops, held issue is not taken, a drain reopens it.
    do_reset();
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 2, 0, 0);
    cyc(0, 0, 0, 1, 3, 0, 0);
    cyc(0, 0, 0, 1, 4, 0, 0);
    chk("full_count", 32'(lq_count), 32'd4);
    ld_issue_valid = 1; ld_issue_rd = 5'd9;
    #1;
    chk("full_ready", 32'(ld_issue_ready), 32'd0);
    cyc(0, 0, 0, 1, 9, 0, 0);
    chk("full_hold_count", 32'(lq_count), 32'd4);
    cyc(0, 0, 0, 0, 0, 1, 32'h1111);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("drain_count", 32'(lq_count), 32'd3);
    chk("drain_wr", {wr_en, 26'b0, wr_addr}, {1'b1, 26'b0, 5'd1});
    ld_issue_rd = 5'd9;
    #1;
    chk("ready_rd9", 32'(ld_issue_ready), 32'd1);
    ld_issue_rd = 5'd1;
    #1;
    chk("ready_rd1_busy", 32'(ld_issue_ready), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("sb1_cleared", 32'(sb_busy[1]), 32'd0);
    chk("no_err_full", 32'(protocol_err), 32'd0);

    // Issue and response together on an empty queue: the response is early.
    do_reset();
    cyc(0, 0, 0, 1, 5, 1, 32'hBAD);
    chk("empty_rsp_err", 32'(protocol_err), 32'd1);
    chk("empty_rsp_count", 32'(lq_count), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("empty_rsp_sticky", 32'(protocol_err), 32'd1);

    // Reset with two loads in flight; their late response is a violation.
    do_reset();
    cyc(0, 0, 0, 1, 6, 0, 0);
    cyc(0, 0, 0, 1, 8, 0, 0);
    chk("pre_rst_count", 32'(lq_count), 32'd2);
    do_reset();
    cyc(0, 0, 0, 0, 0, 1, 32'hCAFE);
    chk("post_rst_rsp_err", 32'(protocol_err), 32'd1);

    // Randomized traffic against the model, with periodic resets.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if (n % 250 == 249) do_reset();
      av = ($urandom % 3) == 0;
      r = 5'($urandom);
      if (($urandom % 10) != 0) begin
        for (int t = 0; t < 8 && m_sb[r]; t++) r = 5'($urandom);
      end
      iv = ($urandom % 2) == 0;
      unfilled = 0;
      foreach (mq[i]) if (!mq[i].filled) unfilled++;
      rv = (unfilled > 0) ? (($urandom % 3) == 0) : (($urandom % 60) == 0);
      cyc(av, r, $urandom, iv, 5'($urandom), rv, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
